// File: rtl/fixed_point_subtract_saturate.sv
// rtl/fixed_point_subtract_saturate.sv - saturating N-bit stage for an (N+1)-bit difference, 2-entry skid, overflow stats (optional counter: FIXED_POINT_SAT_COUNT_EN)
module fixed_point_subtract_saturate #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N:0]       in_diff,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_c,
    output logic             out_carry,
    output logic             out_ovf,
    input  logic             clear_stats,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    // Occupancy state; bit 1 is out_valid, bit 0 marks a held skid entry.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t       state;
    logic         ovf;
    logic [N-1:0] sat_c;
    logic         in_fire;
    logic         out_fire;
    logic [N-1:0] skid_c;
    logic         skid_carry;
    logic         skid_ovf;

    assign out_valid = state[1];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Overflow when the sign bit disagrees with the top result bit; clamp toward the true sign.
    always_comb begin
        ovf   = in_diff[N] ^ in_diff[N-1];
        sat_c = in_diff[N-1:0];
        if (ovf) begin
            sat_c = in_diff[N] ? MIN_NEG : MAX_POS;
        end
    end

    // Output register plus skid entry; in_ready is registered so it never depends on same-cycle handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready   <= 1'b1;
            out_c      <= '0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
            skid_c     <= '0;
            skid_carry <= 1'b0;
            skid_ovf   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        out_c     <= sat_c;
                        out_carry <= in_carry;
                        out_ovf   <= ovf;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        out_c     <= sat_c;
                        out_carry <= in_carry;
                        out_ovf   <= ovf;
                    end else if (in_fire) begin
                        skid_c     <= sat_c;
                        skid_carry <= in_carry;
                        skid_ovf   <= ovf;
                        state      <= FULL;
                        in_ready   <= 1'b0;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        out_c     <= skid_c;
                        out_carry <= skid_carry;
                        out_ovf   <= skid_ovf;
                        state     <= ONE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Sticky flag: clear first so a same-cycle overflow event still sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (in_fire && ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clear_stats) begin
            ovf_sticky <= 1'b0;
        end
    end

`ifdef FIXED_POINT_SAT_COUNT_EN
    // Saturating event counter; a clear coinciding with an event restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (clear_stats) begin
            ovf_count <= (in_fire && ovf) ? CNT_W'(1) : '0;
        end else if (in_fire && ovf && (ovf_count != {CNT_W{1'b1}})) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_fixed_point_subtract_saturate.sv
// tb/tb_fixed_point_subtract_saturate.sv - self-checking bench for fixed_point_subtract_saturate
module tb_fixed_point_subtract_saturate;

    localparam int N     = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef FIXED_POINT_SAT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N:0]       in_diff;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_c;
    logic             out_carry;
    logic             out_ovf;
    logic             clear_stats;
    logic             ovf_sticky;
    logic [CNT_W-1:0] ovf_count;

    fixed_point_subtract_saturate #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_diff(in_diff), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
        .out_carry(out_carry), .out_ovf(out_ovf),
        .clear_stats(clear_stats), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0] c;
        logic         carry;
        logic         ovf;
    } samp_t;

    // Reference: interpret the difference as a signed integer and clamp to the N-bit range.
    function automatic samp_t model(input logic [N:0] d, input logic cy);
        samp_t s;
        int    v;
        int    hi;
        int    lo;
        v  = int'($signed(d));
        hi = (1 << (N - 1)) - 1;
        lo = -(1 << (N - 1));
        s.carry = cy;
        s.ovf   = (v > hi) || (v < lo);
        if (v > hi)      s.c = N'(hi);
        else if (v < lo) s.c = N'(lo);
        else             s.c = N'(v);
        return s;
    endfunction

    samp_t q[$];
    int    m_count   = 0;
    bit    m_sticky  = 1'b0;
    int    out_fires = 0;

    // Compare process: check the DUT against the model, then advance the model to the coming edge.
    always @(negedge clk) begin : monitor
        samp_t s;
        bit    evt;
        evt = 1'b0;
        if (rst) begin
            q.delete();
            m_count  = 0;
            m_sticky = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_sticky", ovf_sticky, 0);
            chk("rst_count", ovf_count, 0);
        end else begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, q.size() < 2);
            chk("ovf_sticky", ovf_sticky, m_sticky);
            chk("ovf_count", ovf_count, CNT_EN ? m_count : 0);
            if (out_valid && q.size() > 0) begin
                chk("out_c", out_c, q[0].c);
                chk("out_carry", out_carry, q[0].carry);
                chk("out_ovf", out_ovf, q[0].ovf);
                if (out_ready) begin
                    void'(q.pop_front());
                    out_fires++;
                end
            end
            if (in_valid && in_ready) begin
                s = model(in_diff, in_carry);
                evt = s.ovf;
                q.push_back(s);
            end
            if (clear_stats) begin
                m_sticky = 1'b0;
                m_count  = 0;
            end
            if (evt) begin
                m_sticky = 1'b1;
                if (m_count < CMAX) m_count++;
            end
        end
    end

    int stalls = 0;

    task automatic send(input logic [N:0] d, input logic cy);
        bit ok;
        bit fired;
        fired    = 1'b0;
        in_valid = 1'b1;
        in_diff  = d;
        in_carry = cy;
        for (int i = 0; i < 50; i++) begin
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                fired = 1'b1;
                break;
            end
            stalls++;
        end
        if (!fired) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base;
        rst = 1'b1; in_valid = 1'b0; in_diff = '0; in_carry = 1'b0;
        out_ready = 1'b1; clear_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_c", out_c, 0);
        chk("reset_out_carry", out_carry, 0);
        chk("reset_out_ovf", out_ovf, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // Basic saturation values
        send(9'h07F, 1'b1);
        chk("lit_7f_c", out_c, 8'h7F);  chk("lit_7f_ovf", out_ovf, 0); chk("lit_7f_carry", out_carry, 1);
        send(9'h1F0, 1'b0);
        chk("lit_f0_c", out_c, 8'hF0);  chk("lit_f0_ovf", out_ovf, 0);
        send(9'h080, 1'b0);
        chk("lit_080_c", out_c, 8'h7F); chk("lit_080_ovf", out_ovf, 1); chk("lit_080_sticky", ovf_sticky, 1);
        send(9'h17F, 1'b1);
        chk("lit_17f_c", out_c, 8'h80); chk("lit_17f_ovf", out_ovf, 1);
        chk("lit_17f_count", ovf_count, CNT_EN ? 2 : 0);
        tick();

        // Backpressure into the skid entry
        out_ready = 1'b0;
        send(9'h001, 1'b0);
        chk("bp_a_c", out_c, 8'h01);
        send(9'h002, 1'b1);
        chk("bp_full_ready", in_ready, 0); chk("bp_full_c", out_c, 8'h01);
        tick();
        chk("bp_hold_c", out_c, 8'h01); chk("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_b_c", out_c, 8'h02); chk("bp_b_ready", in_ready, 1);
        tick();
        chk("bp_drained", out_valid, 0);

        // Streaming, 16 back-to-back samples
        stalls = 0;
        base   = out_fires;
        for (int i = 0; i < 16; i++) send(9'((i * 37 + 5) & 9'h1FF), 1'(i));
        tick();
        chk("stream_stalls", stalls, 0);
        chk("stream_outputs", out_fires - base, 16);

        // Counter saturation and clear-with-event
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clr_sticky", ovf_sticky, 0); chk("clr_count", ovf_count, 0);
        for (int i = 0; i < 5; i++) send(9'h080, 1'b0);
        chk("sat_count", ovf_count, CNT_EN ? 3 : 0); chk("sat_sticky", ovf_sticky, 1);
        clear_stats = 1'b1;
        send(9'h17F, 1'b0);
        clear_stats = 1'b0;
        chk("clr_evt_count", ovf_count, CNT_EN ? 1 : 0); chk("clr_evt_sticky", ovf_sticky, 1);
        tick();

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        send(9'h080, 1'b0);
        send(9'h0F0, 1'b1);
        chk("pre_rst_ready", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0); chk("arst_ready", in_ready, 1);
        chk("arst_sticky", ovf_sticky, 0); chk("arst_count", ovf_count, 0); chk("arst_c", out_c, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(9'h005, 1'b0);
        chk("post_rst_c", out_c, 8'h05); chk("post_rst_valid", out_valid, 1); chk("post_rst_ovf", out_ovf, 0);
        tick();
        chk("post_rst_drained", out_valid, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fixed_point_subtract_saturate.md
Name: fixed_point_subtract_saturate

Overview:
Downstream consumer of FixedPointSubtract. Takes the (N+1)-bit sign-extended difference and carry, detects signed overflow, and saturates to an N-bit two's-complement result. Registered with a valid/ready handshake and a 2-entry skid buffer so the subtractor output can be pipelined into back-pressured consumers. Also keeps sticky and counted overflow statistics.

Parameters:
N, 32, result width in bits; input difference is N+1 bits.
CNT_W, 16, width of the overflow event counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream difference valid.
in_ready  output  1  block can accept this cycle.
in_diff  input  N+1  sign-extended difference from subtractor.
in_carry  input  1  subtractor carry_out, passed through.
out_valid  output  1  out_* fields valid.
out_ready  input  1  downstream accepts this cycle.
out_c  output  N  saturated result.
out_carry  output  1  in_carry of the same sample.
out_ovf  output  1  this sample was saturated.
clear_stats  input  1  synchronous clear of statistics.
ovf_sticky  output  1  set on any accepted overflow sample.
ovf_count  output  CNT_W  accepted overflow samples, saturating.

Behaviour:
- One clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: out_valid=0, out_c=0, out_carry=0, out_ovf=0, in_ready=1, ovf_sticky=0, ovf_count=0. Skid entry is empty.
- Reset asserted mid-transfer discards both held samples. No partial outputs.
- Overflow detect: ovf = in_diff[N] XOR in_diff[N-1].
- Saturation:
  - ovf and in_diff[N]=0: result = 0 followed by N-1 ones (max positive).
  - ovf and in_diff[N]=1: result = 1 followed by N-1 zeros (min negative).
  - Otherwise: result = in_diff[N-1:0].
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready is registered and equals NOT skid_valid.
  - Upstream must hold in_* stable while in_valid=1 and in_ready=0.
- Datapath states, encoded by {out_valid, skid_valid}:
  - EMPTY (0,0): in_fire loads the output register. Next state ONE.
  - ONE (1,0):
    - in_fire & out_fire: reload the output register, stay ONE.
    - in_fire & !out_fire: load skid, go FULL.
    - !in_fire & out_fire: go EMPTY.
  - FULL (1,1): in_ready=0.
    - out_fire: skid moves to the output register, go ONE.
- Latency: sample accepted at edge k appears on out_* after edge k (1 cycle) when not back-pressured.
- Ordering is strictly FIFO. Throughput is 1 sample/cycle with out_ready held high.
- out_* fields are stable while out_valid=1 and out_ready=0.
- Statistics:
  - Update only on in_fire with ovf=1.
  - ovf_sticky: set to 1 on such an event; stays set until cleared.
  - ovf_count: increments and holds at all-ones (no wrap).
  - clear_stats resets both to 0.
  - clear_stats in the same cycle as an overflow event: result is sticky=1, count=1 (clear then count).
- No combinational path from in_valid or out_ready to in_ready.

Optional Feature:
FIXED_POINT_SAT_COUNT_EN.
- Defined: ovf_count register and saturation logic are built as described.
- Undefined: ovf_count is tied to 0 and the counter is not synthesised. ovf_sticky, out_ovf and saturation are unaffected.

Test Plan:
- N=8, in_diff=0x07F, out_ready=1 -> next cycle out_c=0x7F, out_ovf=0. in_diff=0x1F0 -> out_c=0xF0, out_ovf=0.
- N=8, in_diff=0x080 -> out_c=0x7F, out_ovf=1, ovf_sticky=1. in_diff=0x17F -> out_c=0x80, out_ovf=1, ovf_count=2.
- Backpressure, N=8:
  - out_ready=0, push A=0x001 and B=0x002 on consecutive cycles.
  - Expect in_ready=0 the cycle after B is accepted, and out_c=0x01 held.
  - Raise out_ready: A then B delivered on consecutive cycles, in_ready returns to 1.
- Streaming: 16 back-to-back samples with out_ready=1 -> 16 outputs on 16 consecutive cycles, in_ready never deasserts, order preserved.
- CNT_W=2, macro defined: 5 overflow samples -> ovf_count=3 (holds). Pulse clear_stats with a 6th overflow sample in the same cycle -> ovf_count=1, ovf_sticky=1. Macro undefined -> ovf_count stays 0.
- In FULL state, assert rst asynchronously -> out_valid=0, in_ready=1, stats cleared immediately. After release, a new sample emerges with 1-cycle latency and no stale data.
